// File: rtl/mul_div_unit_pkg.sv
// mul_div_unit_pkg: op encodings, width and constants shared by the multiply/divide unit
package mul_div_unit_pkg;
  localparam int MDU_WIDTH = 32;
  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;
  typedef enum logic {MDU_IDLE, MDU_RUN} mdu_state_e;
  localparam logic [MDU_WIDTH-1:0] MDU_DIV_ZERO = '1;
endpackage

// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: execute-stage request/result bundle between controller and multiply/divide unit
interface mul_div_unit_if import mul_div_unit_pkg::*; #(parameter int WIDTH = MDU_WIDTH);
  logic             i_start;
  mdu_op_e          i_op;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_hi_we;
  logic             i_lo_we;
  logic [WIDTH-1:0] i_wdata;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_hi;
  logic [WIDTH-1:0] o_lo;
  modport master (
    output i_start, i_op, i_a, i_b, i_hi_we, i_lo_we, i_wdata,
    input  o_busy, o_done, o_hi, o_lo
  );
  modport slave (
    input  i_start, i_op, i_a, i_b, i_hi_we, i_lo_we, i_wdata,
    output o_busy, o_done, o_hi, o_lo
  );
endinterface

// File: rtl/mul_div_unit_datapath.sv
// mdu_datapath: shared shift-add / restoring-divide accumulator with sign-corrected results
module mdu_datapath import mul_div_unit_pkg::*; #(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_step,
  input  mdu_op_e          i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);
  logic               w_div, w_sgn, w_sa, w_sb, w_ge;
  logic [WIDTH-1:0]   w_ma, w_mb, w_diff, w_quo, w_rem;
  logic [WIDTH:0]     w_sum, w_top;
  logic [2*WIDTH-1:0] w_acc_nxt, w_prod;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;
  logic               r_div, r_neg_q, r_neg_r, r_bzero;
  assign w_div = i_op == MDU_DIV || i_op == MDU_DIVU;
  assign w_sgn = i_op == MDU_MULT || i_op == MDU_DIV;
  assign w_sa  = w_sgn & i_a[WIDTH-1];
  assign w_sb  = w_sgn & i_b[WIDTH-1];
  assign w_ma  = w_sa ? -i_a : i_a;
  assign w_mb  = w_sb ? -i_b : i_b;
  // Low half holds multiplier (mult) or dividend/quotient (div); r_opnd is the addend/divisor.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc   <= '0;
      r_opnd  <= '0;
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_bzero <= 1'b0;
    end else if (i_load) begin
      r_acc   <= {{WIDTH{1'b0}}, w_div ? w_ma : w_mb};
      r_opnd  <= w_div ? w_mb : w_ma;
      r_div   <= w_div;
      r_neg_q <= w_sa ^ w_sb;
      r_neg_r <= w_sa;
      r_bzero <= i_b == '0;
    end else if (i_step) begin
      r_acc <= w_acc_nxt;
    end
  end
  // Results are taken from the next accumulator value so the final step can be written directly.
  always_comb begin
    w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    w_top     = r_acc[2*WIDTH-1:WIDTH-1];
    w_ge      = w_top >= {1'b0, r_opnd};
    w_diff    = w_top[WIDTH-1:0] - r_opnd;
    w_acc_nxt = r_div ? {w_ge ? w_diff : w_top[WIDTH-1:0], r_acc[WIDTH-2:0], w_ge}
                      : {w_sum, r_acc[WIDTH-1:1]};
    w_prod    = r_neg_q ? -w_acc_nxt : w_acc_nxt;
    w_quo     = r_neg_q ? -w_acc_nxt[WIDTH-1:0] : w_acc_nxt[WIDTH-1:0];
    w_rem     = r_neg_r ? -w_acc_nxt[2*WIDTH-1:WIDTH] : w_acc_nxt[2*WIDTH-1:WIDTH];
    o_hi      = r_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
    o_lo      = r_div ? (r_bzero ? MDU_DIV_ZERO : w_quo) : w_prod[WIDTH-1:0];
  end
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MIPS mult/multu/div/divu with private HI/LO and mthi/mtlo writes
module mul_div_unit import mul_div_unit_pkg::*; #(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic           clk,
  input  logic           reset,
  mul_div_unit_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  mdu_state_e       r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic             r_done;
  logic [WIDTH-1:0] r_hi, r_lo, w_res_hi, w_res_lo;
  logic             w_busy, w_load, w_step, w_last;
  always_ff @(posedge clk) begin
    if (reset) r_state <= MDU_IDLE;
    else       r_state <= w_state_nxt;
  end
  always_comb begin
    w_state_nxt = r_state == MDU_IDLE ? (bus.i_start ? MDU_RUN : MDU_IDLE)
                                      : (w_last ? MDU_IDLE : MDU_RUN);
  end
  always_comb begin
    w_busy = r_state == MDU_RUN;
    w_load = !w_busy && bus.i_start;
    w_step = w_busy;
    w_last = w_busy && r_cnt == CW'(WIDTH-1);
  end
  // start takes priority over mthi/mtlo when idle; everything is ignored while busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
      r_hi   <= '0;
      r_lo   <= '0;
    end else begin
      r_cnt  <= w_load ? '0 : (w_step ? r_cnt + 1'b1 : r_cnt);
      r_done <= w_last;
      if (w_last) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end else if (!w_busy && !bus.i_start) begin
        if (bus.i_hi_we) r_hi <= bus.i_wdata;
        if (bus.i_lo_we) r_lo <= bus.i_wdata;
      end
    end
  end
  mdu_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_load),
    .i_step (w_step),
    .i_op   (bus.i_op),
    .i_a    (bus.i_a),
    .i_b    (bus.i_b),
    .o_hi   (w_res_hi),
    .o_lo   (w_res_lo)
  );
  assign bus.o_busy = w_busy;
  assign bus.o_done = r_done;
  assign bus.o_hi   = r_hi;
  assign bus.o_lo   = r_lo;
endmodule
